mul_div_unit: RTL

//  Iterative unsigned 16x16 multiply / 16/16 divide unit in the EX stage, directly downstream of the
//  ID register file. Consumes RD1/RD2 operands. Produces the low result for the write port (WD1/WA1/RegWrite)
//  and the high product or remainder for the dedicated R0 port (R0D/R0W).

---
 rtl/mul_div_pkg.sv | 16 +
 rtl/mul_div_unit_if.sv | 29 ++
 rtl/mul_div_unit_md_step.sv | 39 +++
 rtl/mul_div_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared constants, opcodes and FSM state type for the iterative multiply/divide unit.
package mul_div_pkg;

    localparam int unsigned MD_WIDTH  = 16;
    localparam int unsigned MD_ADDR_W = 4;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage request/result bundle between the pipeline and the multiply/divide unit.
interface mul_div_unit_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              start;
    logic              op;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic [ADDR_W-1:0] wa_in;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  res_lo;
    logic [WIDTH-1:0]  res_hi;
    logic [ADDR_W-1:0] wa_out;
    logic              wr_en;
    logic              r0_we;
    logic              div_zero;

    modport master (
        output start, op, opa, opb, wa_in,
        input  busy, done, res_lo, res_hi, wa_out, wr_en, r0_we, div_zero
    );

    modport slave (
        input  start, op, opa, opb, wa_in,
        output busy, done, res_lo, res_hi, wa_out, wr_en, r0_we, div_zero
    );
endinterface

// File: rtl/mul_div_unit_md_step.sv
// One iteration: MUL shift-add (LSB first) or DIV restoring trial-subtract (MSB first).
module md_step
    import mul_div_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic               op,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_out,
    output logic               q_bit
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             neg;

    always_comb begin
        hi      = acc_in[2*WIDTH-1:WIDTH];
        lo      = acc_in[WIDTH-1:0];
        sum     = {1'b0, hi} + {1'b0, operand};
        rem_sh  = {hi, lo[WIDTH-1]};
        neg     = rem_sh < {1'b0, operand};
        // A successful trial always leaves a remainder below the divisor, so W bits suffice.
        diff    = rem_sh[WIDTH-1:0] - operand;
        acc_out = '0;
        q_bit   = 1'b0;
        if (op == OP_MUL) begin
            acc_out = lo[0] ? {sum, lo[WIDTH-1:1]} : {1'b0, hi, lo[WIDTH-1:1]};
        end else begin
            q_bit   = ~neg;
            acc_out = {(neg ? rem_sh[WIDTH-1:0] : diff), lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: FSM, iteration counter, operand latches and result registers.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int unsigned WIDTH  = MD_WIDTH,
    parameter int unsigned ADDR_W = MD_ADDR_W
) (
    input logic           clk,
    input logic           rst,
    mul_div_unit_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0]  wa_q, wa_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [ADDR_W-1:0]  wa_out_q, wa_out_d;
    logic               div_zero_q, div_zero_d;

    logic [2*WIDTH-1:0] step_acc;
    logic               step_q;
    logic               accept;
    logic               last;

    md_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .acc_in  (acc_q),
        .operand (operand_q),
        .acc_out (step_acc),
        .q_bit   (step_q)
    );

    assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last   = (state_q == ST_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            operand_q  <= '0;
            opa_q      <= '0;
            dz_q       <= 1'b0;
            acc_q      <= '0;
            wa_q       <= '0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
            wa_out_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            operand_q  <= operand_d;
            opa_q      <= opa_d;
            dz_q       <= dz_d;
            acc_q      <= acc_d;
            wa_q       <= wa_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
            wa_out_q   <= wa_out_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last)   state_d = ST_DONE;
            ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q == ST_RUN);
        bus.done     = (state_q == ST_DONE);
        bus.wr_en    = (state_q == ST_DONE);
        bus.r0_we    = (state_q == ST_DONE);
        bus.res_lo   = res_lo_q;
        bus.res_hi   = res_hi_q;
        bus.wa_out   = wa_out_q;
        bus.div_zero = div_zero_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        operand_d  = operand_q;
        opa_d      = opa_q;
        dz_d       = dz_q;
        acc_d      = acc_q;
        wa_d       = wa_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        wa_out_d   = wa_out_q;
        div_zero_d = div_zero_q;
        if (accept) begin
            cnt_d     = '0;
            op_d      = bus.op;
            operand_d = (bus.op == OP_DIV) ? bus.opb : bus.opa;
            acc_d     = {{WIDTH{1'b0}}, ((bus.op == OP_DIV) ? bus.opa : bus.opb)};
            opa_d     = bus.opa;
            dz_d      = (bus.op == OP_DIV) && (bus.opb == '0);
            wa_d      = bus.wa_in;
        end else if (state_q == ST_RUN) begin
            // The step leaves the accumulator LSB clear on DIV; the quotient bit is merged here.
            acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
            if (!last) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                res_lo_d   = dz_q ? '1 : acc_d[WIDTH-1:0];
                res_hi_d   = dz_q ? opa_q : acc_d[2*WIDTH-1:WIDTH];
                wa_out_d   = wa_q;
                div_zero_d = dz_q;
            end
        end
    end

endmodule
